// File: rtl/kan_core_sequencer.sv
// kan_core_sequencer: run controller for one KAN processing core.
// Loads a block of spline coefficients into the core's write port. It then
// holds the compute enable for one full PE round-robin, and finally waits
// for the core's all-PEs-ready flag. That wait has an optional timeout.
module kan_core_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_PES     = 64,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH:0]   cfg_num_words,
  input  logic [TIMER_WIDTH-1:0] cfg_timeout,
  input  logic                  coeff_valid,
  input  logic [DATA_WIDTH-1:0] coeff_data,
  output logic                  coeff_ready,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic                  core_we,
  output logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_enable,
  input  logic                  core_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int SWEEP_W = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
  localparam logic [SWEEP_W-1:0]     SWEEP_LAST = SWEEP_W'(NUM_PES - 1);
  localparam logic [SWEEP_W-1:0]     SWEEP_ONE  = SWEEP_W'(1);
  localparam logic [ADDR_WIDTH:0]    WL_ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);

  logic [2:0]             r_state;
  logic [2:0]             w_state_next;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [ADDR_WIDTH:0]    r_num_words;
  logic [TIMER_WIDTH-1:0] r_timeout;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [SWEEP_W-1:0]     r_sweep_cnt;
  logic [ADDR_WIDTH:0]    r_words_loaded;
  logic                   r_core_we;
  logic [ADDR_WIDTH-1:0]  r_core_addr;
  logic [DATA_WIDTH-1:0]  r_core_wdata;
  logic                   r_error;
  logic                   w_hs;
  logic                   w_last_word;
  logic                   w_timeout_hit;
  logic                   w_accept_start;

  // coeff_ready is decoded from state alone, so the source never sees a
  // combinational loop back through coeff_valid.
  assign coeff_ready  = (r_state == S_LOAD);
  assign core_enable  = (r_state == S_SWEEP);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign core_we      = r_core_we;
  assign core_addr    = r_core_addr;
  assign core_wdata   = r_core_wdata;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

  // An abort cycle's handshake is dropped entirely, so it is masked here.
  assign w_hs           = coeff_valid && coeff_ready && !abort;
  assign w_last_word    = ((r_words_loaded + WL_ONE) == r_num_words);
  assign w_accept_start = (r_state == S_IDLE) && start;
  // A ready core wins over the timeout when both land in the same cycle.
  assign w_timeout_hit  = (r_state == S_WAIT) && !core_ready && (r_timeout != '0)
                          && (r_timer == (r_timeout - TIMER_ONE));

  // Next-state decode; abort overrides every non-idle transition.
  always_comb begin
    // NOTE: default assignment first so every path drives w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (cfg_num_words == '0) ? S_SWEEP : S_LOAD;
      S_LOAD:  if (w_hs && w_last_word) w_state_next = S_SWEEP;
      S_SWEEP: if (r_sweep_cnt == SWEEP_LAST) w_state_next = S_WAIT;
      S_WAIT:  if (core_ready || w_timeout_hit) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Config capture, the write pipeline, the counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base         <= '0;
      r_num_words    <= '0;
      r_timeout      <= '0;
      r_timer        <= '0;
      r_sweep_cnt    <= '0;
      r_words_loaded <= '0;
      r_core_we      <= 1'b0;
      r_core_addr    <= '0;
      r_core_wdata   <= '0;
      r_error        <= 1'b0;
    end else begin
      r_core_we <= 1'b0;
      if (w_accept_start) begin
        r_base         <= cfg_base_addr;
        r_num_words    <= cfg_num_words;
        r_timeout      <= cfg_timeout;
        r_error        <= 1'b0;
        r_words_loaded <= '0;
      end
      if (w_hs) begin
        r_core_we      <= 1'b1;
        r_core_addr    <= r_base + r_words_loaded[ADDR_WIDTH-1:0];
        r_core_wdata   <= coeff_data;
        r_words_loaded <= r_words_loaded + WL_ONE;
      end
      // Both counters restart from zero on entry to their state.
      r_sweep_cnt <= ((r_state == S_SWEEP) && (w_state_next == S_SWEEP))
                     ? r_sweep_cnt + SWEEP_ONE : '0;
      r_timer     <= ((r_state == S_WAIT) && (w_state_next == S_WAIT))
                     ? r_timer + TIMER_ONE : '0;
      if (w_timeout_hit && !abort) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kan_core_sequencer.sv
// Directed bench for kan_core_sequencer with a write scoreboard.
module tb_kan_core_sequencer;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_base_addr;
  logic [16:0] cfg_num_words;
  logic [15:0] cfg_timeout;
  logic        coeff_valid;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic [15:0] core_addr;
  logic        core_we;
  logic [15:0] core_wdata;
  logic        core_enable;
  logic        core_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [16:0] words_loaded;

  int  checks;
  int  failures;
  int  we_cnt;
  int  en_cnt;
  int  done_cnt;
  wr_t exp_q[$];

  kan_core_sequencer #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_PES(64), .TIMER_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .cfg_timeout(cfg_timeout), .coeff_valid(coeff_valid),
    .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
    .core_enable(core_enable), .core_ready(core_ready), .busy(busy),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_enable) en_cnt++;
      if (done) done_cnt++;
      if (core_we) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          check("we_unexpected_qsize", exp_q.size(), 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("we_addr", core_addr, e.addr);
          check("we_data", core_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source model: presents words, pushes an expected write on each handshake.
  task automatic feed(input int n, input bit toggle, input logic [15:0] base,
                      input int abort_idx, input bit poke_start, output int cycles);
    int  idx;
    bit  aborted;
    idx     = 0;
    cycles  = 0;
    aborted = 1'b0;
    while (idx < n && cycles < 100) begin
      coeff_valid = toggle ? ~cycles[0] : 1'b1;
      coeff_data  = 16'h00A0 + 16'(idx);
      abort       = coeff_valid && (idx == abort_idx);
      if (poke_start && cycles == 1) begin
        start         = 1'b1;
        cfg_base_addr = 16'h5555;
        cfg_num_words = 17'd1;
      end
      @(negedge clk);
      if (coeff_valid && coeff_ready) begin
        if (abort) aborted = 1'b1;
        else exp_q.push_back('{addr: base + 16'(idx), data: coeff_data});
        idx++;
      end
      @(posedge clk); #1;
      cycles++;
      abort = 1'b0;
      start = 1'b0;
      if (aborted) break;
    end
    coeff_valid = 1'b0;
    if (!aborted) check("feed_complete", idx, n);
  endtask

  // One full run: start, load (or skip), sweep, wait, done.
  // rd > 0 raises core_ready during WAIT cycle rd; rd <= 0 never raises it.
  task automatic run(input logic [15:0] base, input logic [16:0] num,
                     input logic [15:0] tmo, input bit toggle, input int rd);
    int we0, en0, dn0, wait_n, cyc;
    bit seen_done;
    we0 = we_cnt; en0 = en_cnt; dn0 = done_cnt;
    cfg_base_addr = base;
    cfg_num_words = num;
    cfg_timeout   = tmo;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_error_clr", error, 0);
    check("start_wl_clr", words_loaded, 0);
    if (num != 0) begin
      feed(int'(num), toggle, base, -1, 1'b0, cyc);
      if (!toggle) check("load_cycles", cyc, int'(num));
      @(negedge clk);
      check("last_we_first_sweep", {core_we, core_enable}, 2'b11);
    end else begin
      @(negedge clk);
      check("zero_no_ready", coeff_ready, 0);
      check("zero_sweep_next", core_enable, 1);
    end
    wait_n = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      else if (busy && !core_enable) begin
        wait_n++;
        if (wait_n == rd) core_ready = 1'b1;
      end
    end
    core_ready = 1'b0;
    check("done_seen", seen_done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("wait_len", wait_n, (rd > 0) ? rd : int'(tmo));
    check("error_flag", error, (rd <= 0 && tmo != 0) ? 1 : 0);
    check("words_loaded", words_loaded, 32'(num));
    check("we_count", we_cnt - we0, 32'(num));
    check("enable_len", en_cnt - en0, 64);
    check("done_count", done_cnt - dn0, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int cyc, we0, en0, dn0;
    checks = 0; failures = 0; we_cnt = 0; en_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_base_addr = '0; cfg_num_words = '0; cfg_timeout = '0;
    coeff_valid = 1'b0; coeff_data = '0; core_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {coeff_ready, core_we, core_enable, busy, done, error},
          6'b0);
    check("rst_addr", core_addr, 0);
    check("rst_wdata", core_wdata, 0);
    check("rst_wl", words_loaded, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous source, ready after 10 WAIT cycles.
    run(16'h0100, 17'd4, 16'd0, 1'b0, 10);
    // Source valid every other cycle.
    @(posedge clk); #1;
    run(16'h0100, 17'd4, 16'd0, 1'b1, 10);
    // Address wrap past 0xFFFF.
    @(posedge clk); #1;
    run(16'hFFFE, 17'd4, 16'd0, 1'b0, 3);
    // Zero-length load goes straight to SWEEP.
    @(posedge clk); #1;
    run(16'h0300, 17'd0, 16'd0, 1'b0, 5);
    // Timeout with core_ready held low.
    @(posedge clk); #1;
    run(16'h0400, 17'd2, 16'd20, 1'b0, 0);
    // Next start clears error; ready on the last allowed cycle wins.
    @(posedge clk); #1;
    run(16'h0400, 17'd2, 16'd20, 1'b0, 20);

    // Abort on the 3rd handshake; a start pulse mid-load is ignored.
    @(posedge clk); #1;
    we0 = we_cnt; en0 = en_cnt; dn0 = done_cnt;
    cfg_base_addr = 16'h0200; cfg_num_words = 17'd8; cfg_timeout = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(8, 1'b0, 16'h0200, 2, 1'b1, cyc);
    check("abort_cycle", cyc, 3);
    check("abort_idle", busy, 0);
    check("abort_no_ready", coeff_ready, 0);
    check("abort_no_we", core_we, 0);
    cfg_base_addr = 16'h0200; cfg_num_words = 17'd8;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_no_enable", en_cnt - en0, 0);
    check("abort_writes", we_cnt - we0, 2);
    check("abort_queue", exp_q.size(), 0);
    check("abort_error_kept", error, 0);

    // Asynchronous reset in the middle of SWEEP.
    @(posedge clk); #1;
    cfg_num_words = 17'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_enable", core_enable, 1);
    rst_n = 1'b0;
    #1;
    check("rst_enable_drop", core_enable, 0);
    check("rst_busy_drop", busy, 0);
    check("rst_addr_clear", core_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
